// File: rtl/echo_pkg.sv
// Shared definitions for the echo frame capture block: default frame size,
// FSM state encoding and frame-counter width.
package echo_pkg;

    localparam int POINTS_DEF  = 400;
    localparam int DLY_W_DEF   = 10;
    localparam int CNT_W_DEF   = 9;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLANK   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/echo_frame_capture_if.sv
// Bundles the trigger/echo inputs and frame outputs of echo_frame_capture.
// The master modport is the stimulus/front-end view; slave is the capture block.
interface echo_frame_capture_if
    import echo_pkg::*;
#(
    parameter int POINTS = POINTS_DEF,
    parameter int DLY_W  = DLY_W_DEF
);
    logic                   cap_en;
    logic                   fire_trig;
    logic [DLY_W-1:0]       start_dly;
    logic                   echo_in;
    logic                   tola_en;
    logic [POINTS-1:0]      total_data;
    logic                   busy;
    logic                   trig_drop;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        output cap_en, fire_trig, start_dly, echo_in,
        input  tola_en, total_data, busy, trig_drop, frame_cnt
    );

    modport slave (
        input  cap_en, fire_trig, start_dly, echo_in,
        output tola_en, total_data, busy, trig_drop, frame_cnt
    );

endinterface

// File: rtl/echo_sync2.sv
// Two-flop synchronizer for the asynchronous echo comparator output.
module echo_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/echo_frame_capture.sv
// Packs POINTS echo samples taken after each laser trigger (plus blanking delay)
// into one frame with a one-cycle strobe. Define ECHO_SYNC_EN to resynchronize echo_in.
module echo_frame_capture
    import echo_pkg::*;
#(
    parameter int POINTS = POINTS_DEF,
    parameter int DLY_W  = DLY_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)(
    input  logic                clk,
    input  logic                rst,
    echo_frame_capture_if.slave bus
);
    state_t                 r_state;
    logic [DLY_W-1:0]       r_dly_cnt;
    logic [CNT_W-1:0]       r_cnt;
    logic [POINTS-1:0]      r_sh;
    logic [POINTS-1:0]      r_total;
    logic                   r_tola;
    logic                   r_drop;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   w_echo;
    logic                   w_trig;

`ifdef ECHO_SYNC_EN
    echo_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.echo_in),
        .o_q (w_echo)
    );
`else
    assign w_echo = bus.echo_in;
`endif

    assign w_trig = bus.fire_trig & bus.cap_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_dly_cnt   <= '0;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_total     <= '0;
            r_tola      <= 1'b0;
            r_drop      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_tola <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_dly_cnt <= bus.start_dly;
                        r_state   <= (bus.start_dly == '0) ? CAPTURE : BLANK;
                    end
                end
                BLANK: begin
                    r_drop    <= bus.fire_trig;
                    r_dly_cnt <= r_dly_cnt - 1'b1;
                    if (r_dly_cnt == DLY_W'(1))
                        r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_drop <= bus.fire_trig;
                    // The last sample goes straight into the output so the frame
                    // appears whole; the shift register restarts clean.
                    if (r_cnt == CNT_W'(POINTS - 1)) begin
                        r_total     <= {w_echo, r_sh[POINTS-1:1]};
                        r_sh        <= '0;
                        r_cnt       <= '0;
                        r_tola      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_sh  <= {w_echo, r_sh[POINTS-1:1]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tola_en    = r_tola;
    assign bus.total_data = r_total;
    assign bus.busy       = (r_state != IDLE);
    assign bus.trig_drop  = r_drop;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
